// File: rtl/rand_pkg.sv
// Shared definitions for the ranged LFSR random source: tap masks, FSM encoding,
// and a parameter-legality guard used at elaboration.
package rand_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    HOLD   = 2'd2
  } rand_state_e;

  // Low-order terms of a primitive polynomial of degree width; bit k set means
  // r[k] feeds the XOR that enters at the MSB.
  function automatic logic [15:0] TAPS(input int width);
    case (width)
      3:       TAPS = 16'h0003;
      4:       TAPS = 16'h0003;
      5:       TAPS = 16'h0005;
      6:       TAPS = 16'h0003;
      7:       TAPS = 16'h0003;
      8:       TAPS = 16'h001D;
      9:       TAPS = 16'h0011;
      10:      TAPS = 16'h0009;
      11:      TAPS = 16'h0005;
      12:      TAPS = 16'h0053;
      13:      TAPS = 16'h001B;
      14:      TAPS = 16'h0443;
      15:      TAPS = 16'h0003;
      16:      TAPS = 16'h100B;
      default: TAPS = 16'h0003;
    endcase
  endfunction

endpackage

`define RAND_PARAM_CHECK(label, cond) \
  if (!(cond)) begin : label \
    $error("lfsr_rand_range: illegal parameter set"); \
  end

// File: rtl/lfsr_core.sv
// Right-shifting Fibonacci LFSR with seed load; a zero seed is replaced by 1
// so the all-zero lock-up state can never be entered.
module lfsr_core
  import rand_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SEED  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             adv,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q
);

  localparam logic [15:0]      TAP_MASK = TAPS(WIDTH);
  localparam logic [WIDTH-1:0] SEED_V   = WIDTH'(SEED);

  logic fb;
  assign fb = ^(q & TAP_MASK[WIDTH-1:0]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= SEED_V;
    end else if (load) begin
      q <= (load_val == '0) ? WIDTH'(1) : load_val;
    end else if (adv) begin
      q <= {fb, q[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/lfsr_rand_range.sv
// Ranged random source: rejection-samples the LFSR low bits into [0, RANGE_MAX)
// and falls back to cand-RANGE_MAX after MAX_TRIES rejections.
module lfsr_rand_range
  import rand_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int OUT_W     = 6,
  parameter int RANGE_MAX = 40,
  parameter int SEED      = 1,
  parameter int MAX_TRIES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step_en,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             req,
  output logic             rand_valid,
  input  logic             rand_ready,
  output logic [OUT_W-1:0] rand_out,
  output logic             fallback,
  output logic             busy,
  output logic [WIDTH-1:0] raw_q
);

  `RAND_PARAM_CHECK(g_param_check,
    (WIDTH >= 3) && (WIDTH <= 16) && (OUT_W >= 1) && (OUT_W <= WIDTH) &&
    (RANGE_MAX > (1 << (OUT_W - 1))) && (RANGE_MAX <= (1 << OUT_W)) &&
    ((SEED & ((1 << WIDTH) - 1)) != 0) && (MAX_TRIES >= 1))

  localparam int              TW   = $clog2(MAX_TRIES + 1);
  localparam logic [TW-1:0]   LAST = TW'(MAX_TRIES - 1);
  localparam logic [OUT_W:0]  RMAX = (OUT_W + 1)'(RANGE_MAX);

  rand_state_e     state;
  logic [TW-1:0]   tries;
  logic [WIDTH-1:0] r;
  logic            adv;
  logic [OUT_W:0]  cand_x;

  // SEARCH consumes one LFSR state per cycle; elsewhere the LFSR only moves on step_en.
  assign adv    = (state == SEARCH) || step_en;
  assign cand_x = {1'b0, r[OUT_W-1:0]};

  lfsr_core #(
    .WIDTH (WIDTH),
    .SEED  (SEED)
  ) u_lfsr (
    .clk      (clk),
    .reset    (reset),
    .adv      (adv),
    .load     (seed_load),
    .load_val (seed_in),
    .q        (r)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      tries    <= '0;
      rand_out <= '0;
      fallback <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            state <= SEARCH;
            tries <= '0;
          end
        end
        SEARCH: begin
          if (cand_x < RMAX) begin
            rand_out <= cand_x[OUT_W-1:0];
            fallback <= 1'b0;
            state    <= HOLD;
          end else if (tries == LAST) begin
            // cand < 2^OUT_W <= 2*RANGE_MAX, so the difference is already in range
            rand_out <= OUT_W'(cand_x - RMAX);
            fallback <= 1'b1;
            state    <= HOLD;
          end else begin
            tries <= tries + 1'b1;
          end
        end
        HOLD: begin
          if (rand_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rand_valid = (state == HOLD);
  assign busy       = (state == SEARCH);
  assign raw_q      = r;

endmodule
